decode_scoreboard: RTL and testbench

DECODE_SCOREBOARD -- requirements
Module: decode_scoreboard

---
 rtl/decode_pkg.sv | 10 +
 rtl/sb_counter.sv | 27 ++
 rtl/decode_scoreboard.sv | 105 ++++++++++
 tb/tb_decode_scoreboard.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared defaults for the decode-stage scoreboard.
package decode_pkg;
  localparam int DATA_W_D = 16;
  localparam int NREG_D = 8;
  localparam int CNT_W_D = 2;
  function automatic int max_cnt(input int w);
    return (1 << w) - 1;
  endfunction
  localparam int MAX_CNT = max_cnt(CNT_W_D);
endpackage

// File: rtl/sb_counter.sv
// sb_counter: one pending-write counter.
// Ports: clk, reset (sync, active-high), inc/dec requests,
// full (at max), nonzero (writes pending), underflow (dec seen while zero).
module sb_counter
  import decode_pkg::*;
#(
  parameter int CNT_W = CNT_W_D
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic nonzero,
  output logic underflow
);
  logic [CNT_W-1:0] r_cnt;
  assign full = &r_cnt;
  assign nonzero = |r_cnt;
  assign underflow = dec & ~nonzero;
  // inc+dec together cancel; a dec of zero and an inc of full are dropped
  always_ff @(posedge clk) begin
    if (reset) r_cnt <= '0;
    else if (inc & ~dec & ~full) r_cnt <= r_cnt + CNT_W'(1);
    else if (dec & ~inc & nonzero) r_cnt <= r_cnt - CNT_W'(1);
  end
endmodule

// File: rtl/decode_scoreboard.sv
// decode_scoreboard: DE-stage hazard scoreboard feeding the AGEX latch.
// Ports: de_* decoded instruction, mem_stall/flush control, wb_* retiring
// writes; dep_stall hazard, ld_agex/agex_* latch, busy_mask/cc_pending
// pending-write view, sb_err sticky underflow.
module decode_scoreboard
  import decode_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int NREG = NREG_D,
  parameter int RID_W = $clog2(NREG),
  parameter int PAYLOAD_W = 2*DATA_W+20,
  parameter int CNT_W = CNT_W_D
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 de_v,
  input  logic [RID_W-1:0]     de_sr1_id,
  input  logic [RID_W-1:0]     de_sr2_id,
  input  logic                 de_sr1_needed,
  input  logic                 de_sr2_needed,
  input  logic [RID_W-1:0]     de_dr_id,
  input  logic                 de_ld_reg,
  input  logic                 de_ld_cc,
  input  logic                 de_br_op,
  input  logic [PAYLOAD_W-1:0] de_payload,
  input  logic                 mem_stall,
  input  logic                 flush,
  input  logic                 wb_ld_reg,
  input  logic                 wb_ld_cc,
  input  logic [RID_W-1:0]     wb_drid,
  output logic                 dep_stall,
  output logic                 ld_agex,
  output logic                 agex_v,
  output logic [PAYLOAD_W-1:0] agex_payload,
  output logic [RID_W-1:0]     agex_drid,
  output logic                 agex_ld_reg,
  output logic                 agex_ld_cc,
  output logic [NREG-1:0]      busy_mask,
  output logic                 cc_pending,
  output logic                 sb_err
);
  logic [NREG-1:0] w_full;
  logic [NREG:0]   w_uf;
  logic            w_cc_full;
  logic            w_issue;
  logic            r_agex_v;
  logic [PAYLOAD_W-1:0] r_agex_payload;
  logic [RID_W-1:0] r_agex_drid;
  logic            r_agex_ld_reg;
  logic            r_agex_ld_cc;
  logic            r_sb_err;
  // hazards come from registered counts only; a same-cycle writeback does not unblock
  assign dep_stall = de_v & ((de_sr1_needed & busy_mask[de_sr1_id]) |
                             (de_sr2_needed & busy_mask[de_sr2_id]) |
                             (de_br_op & cc_pending) |
                             (de_ld_reg & w_full[de_dr_id]) |
                             (de_ld_cc & w_cc_full));
  assign w_issue = de_v & ~dep_stall & ~mem_stall & ~flush;
  assign ld_agex = ~mem_stall;
  for (genvar i = 0; i < NREG; i++) begin : g_reg
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .inc      (w_issue & de_ld_reg & (de_dr_id == RID_W'(i))),
      .dec      (wb_ld_reg & (wb_drid == RID_W'(i))),
      .full     (w_full[i]),
      .nonzero  (busy_mask[i]),
      .underflow(w_uf[i])
    );
  end
  sb_counter #(.CNT_W(CNT_W)) u_cc (
    .clk      (clk),
    .reset    (reset),
    .inc      (w_issue & de_ld_cc),
    .dec      (wb_ld_cc),
    .full     (w_cc_full),
    .nonzero  (cc_pending),
    .underflow(w_uf[NREG])
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_agex_v <= 1'b0;
      r_agex_payload <= '0;
      r_agex_drid <= '0;
      r_agex_ld_reg <= 1'b0;
      r_agex_ld_cc <= 1'b0;
      r_sb_err <= 1'b0;
    end else begin
      r_sb_err <= r_sb_err | (|w_uf);
      if (!mem_stall) begin
        r_agex_v <= w_issue;
        r_agex_payload <= de_payload;
        r_agex_drid <= de_dr_id;
        r_agex_ld_reg <= de_ld_reg;
        r_agex_ld_cc <= de_ld_cc;
      end
    end
  end
  assign agex_v = r_agex_v;
  assign agex_payload = r_agex_payload;
  assign agex_drid = r_agex_drid;
  assign agex_ld_reg = r_agex_ld_reg;
  assign agex_ld_cc = r_agex_ld_cc;
  assign sb_err = r_sb_err;
endmodule

// File: tb/tb_decode_scoreboard.sv
// tb_decode_scoreboard: directed and random checks against a counting model.
module tb_decode_scoreboard;
  localparam int NREG = 8;
  localparam int RW = 3;
  localparam int PW = 52;
  localparam int MAXC = 3;
  logic clk = 1'b0;
  logic reset, de_v, de_sr1_needed, de_sr2_needed, de_ld_reg, de_ld_cc, de_br_op;
  logic [RW-1:0] de_sr1_id, de_sr2_id, de_dr_id, wb_drid;
  logic [PW-1:0] de_payload;
  logic mem_stall, flush, wb_ld_reg, wb_ld_cc;
  logic dep_stall, ld_agex, agex_v, agex_ld_reg, agex_ld_cc, cc_pending, sb_err;
  logic [PW-1:0] agex_payload;
  logic [RW-1:0] agex_drid;
  logic [NREG-1:0] busy_mask;
  int checks = 0;
  int errors = 0;
  int m_cnt[NREG];
  int m_cc;
  bit m_err, m_agv, m_alr, m_alc;
  logic [PW-1:0] m_pay;
  logic [RW-1:0] m_drid;

  decode_scoreboard dut (
    .clk(clk), .reset(reset), .de_v(de_v), .de_sr1_id(de_sr1_id), .de_sr2_id(de_sr2_id),
    .de_sr1_needed(de_sr1_needed), .de_sr2_needed(de_sr2_needed), .de_dr_id(de_dr_id),
    .de_ld_reg(de_ld_reg), .de_ld_cc(de_ld_cc), .de_br_op(de_br_op), .de_payload(de_payload),
    .mem_stall(mem_stall), .flush(flush), .wb_ld_reg(wb_ld_reg), .wb_ld_cc(wb_ld_cc),
    .wb_drid(wb_drid), .dep_stall(dep_stall), .ld_agex(ld_agex), .agex_v(agex_v),
    .agex_payload(agex_payload), .agex_drid(agex_drid), .agex_ld_reg(agex_ld_reg),
    .agex_ld_cc(agex_ld_cc), .busy_mask(busy_mask), .cc_pending(cc_pending), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  function automatic bit m_stall();
    return de_v && ((de_sr1_needed && m_cnt[de_sr1_id] != 0) || (de_sr2_needed && m_cnt[de_sr2_id] != 0) ||
                    (de_br_op && m_cc != 0) || (de_ld_reg && m_cnt[de_dr_id] == MAXC) ||
                    (de_ld_cc && m_cc == MAXC));
  endfunction

  function automatic logic [NREG-1:0] m_busy();
    logic [NREG-1:0] b;
    for (int i = 0; i < NREG; i++) b[i] = m_cnt[i] != 0;
    return b;
  endfunction

  function automatic logic [PW-1:0] rnd_pay();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[PW-1:0];
  endfunction

  task automatic idle();
    reset = 0; de_v = 0; de_sr1_id = 0; de_sr2_id = 0; de_sr1_needed = 0; de_sr2_needed = 0;
    de_dr_id = 0; de_ld_reg = 0; de_ld_cc = 0; de_br_op = 0; de_payload = 0;
    mem_stall = 0; flush = 0; wb_ld_reg = 0; wb_ld_cc = 0; wb_drid = 0;
  endtask

  // advance one clock and apply the scoreboard rules to the model
  task automatic tick();
    bit iss, inc, dec;
    iss = de_v && !m_stall() && !mem_stall && !flush;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
      m_cc = 0; m_err = 0; m_agv = 0; m_pay = '0; m_drid = '0; m_alr = 0; m_alc = 0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        inc = iss && de_ld_reg && de_dr_id == i;
        dec = wb_ld_reg && wb_drid == i;
        if (dec && m_cnt[i] == 0) m_err = 1;
        if (inc && !dec && m_cnt[i] < MAXC) m_cnt[i]++;
        else if (dec && !inc && m_cnt[i] > 0) m_cnt[i]--;
      end
      inc = iss && de_ld_cc;
      dec = wb_ld_cc;
      if (dec && m_cc == 0) m_err = 1;
      if (inc && !dec && m_cc < MAXC) m_cc++;
      else if (dec && !inc && m_cc > 0) m_cc--;
      if (!mem_stall) begin
        m_agv = iss; m_pay = de_payload; m_drid = de_dr_id; m_alr = de_ld_reg; m_alc = de_ld_cc;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle(); reset = 1; tick(); reset = 0;
  endtask

  task automatic test_reset();
    idle(); reset = 1;
    de_v = 1; de_ld_reg = 1; de_dr_id = 2; wb_ld_reg = 1; wb_drid = 6; de_payload = rnd_pay();
    tick(); tick();
    #1;
    checks++; if (dep_stall !== 1'b0) begin errors++; $display("FAIL reset_dep_stall got %b exp 0", dep_stall); end
    checks++; if (agex_v !== 1'b0) begin errors++; $display("FAIL reset_agex_v got %b exp 0", agex_v); end
    checks++; if (agex_payload !== '0) begin errors++; $display("FAIL reset_payload got %h exp 0", agex_payload); end
    checks++; if (busy_mask !== '0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_mask); end
    checks++; if (cc_pending !== 1'b0) begin errors++; $display("FAIL reset_cc got %b exp 0", cc_pending); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", sb_err); end
    idle();
    @(negedge clk);
  endtask

  task automatic test_raw();
    logic [PW-1:0] p;
    do_reset();
    p = rnd_pay();
    de_v = 1; de_ld_reg = 1; de_dr_id = 3; de_payload = p;
    #1;
    checks++; if (dep_stall !== 1'b0) begin errors++; $display("FAIL raw_first_stall got %b exp 0", dep_stall); end
    tick();
    checks++; if (agex_v !== 1'b1 || agex_drid !== 3'd3 || agex_payload !== p) begin
      errors++; $display("FAIL raw_issue got v=%b dr=%0d p=%h exp v=1 dr=3 p=%h", agex_v, agex_drid, agex_payload, p); end
    de_ld_reg = 0; de_dr_id = 0; de_sr1_needed = 1; de_sr1_id = 3;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (dep_stall !== 1'b1) begin errors++; $display("FAIL raw_wait%0d got %b exp 1", k, dep_stall); end
      tick();
      checks++; if (agex_v !== 1'b0) begin errors++; $display("FAIL raw_bubble%0d got %b exp 0", k, agex_v); end
    end
    wb_ld_reg = 1; wb_drid = 3;
    #1;
    checks++; if (dep_stall !== 1'b1) begin errors++; $display("FAIL raw_no_bypass got %b exp 1", dep_stall); end
    tick();
    wb_ld_reg = 0;
    #1;
    checks++; if (dep_stall !== 1'b0 || busy_mask !== '0) begin
      errors++; $display("FAIL raw_release got stall=%b busy=%b exp 0/0", dep_stall, busy_mask); end
    tick();
    checks++; if (agex_v !== 1'b1) begin errors++; $display("FAIL raw_dep_issue got %b exp 1", agex_v); end
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    de_v = 1; de_ld_reg = 1; de_dr_id = 1;
    for (int k = 0; k < 3; k++) begin
      de_payload = rnd_pay();
      #1;
      checks++; if (dep_stall !== 1'b0) begin errors++; $display("FAIL b2b_stall%0d got %b exp 0", k, dep_stall); end
      tick();
      checks++; if (agex_v !== 1'b1) begin errors++; $display("FAIL b2b_issue%0d got %b exp 1", k, agex_v); end
    end
    #1;
    checks++; if (dep_stall !== 1'b1) begin errors++; $display("FAIL b2b_full got %b exp 1", dep_stall); end
    tick();
    checks++; if (agex_v !== 1'b0 || busy_mask !== 8'b0000_0010) begin
      errors++; $display("FAIL b2b_blocked got v=%b busy=%b exp 0/00000010", agex_v, busy_mask); end
    idle(); wb_ld_reg = 1; wb_drid = 1;
    for (int k = 0; k < 3; k++) tick();
    wb_ld_reg = 0;
    checks++; if (busy_mask !== '0 || sb_err !== 1'b0) begin
      errors++; $display("FAIL b2b_drain got busy=%b err=%b exp 0/0", busy_mask, sb_err); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    de_v = 1; de_ld_reg = 1; de_dr_id = 2;
    tick();
    wb_ld_reg = 1; wb_drid = 2;
    #1;
    checks++; if (dep_stall !== 1'b0) begin errors++; $display("FAIL same_stall got %b exp 0", dep_stall); end
    tick();
    checks++; if (busy_mask !== 8'b0000_0100 || agex_v !== 1'b1) begin
      errors++; $display("FAIL same_hold got busy=%b v=%b exp 00000100/1", busy_mask, agex_v); end
    de_v = 0;
    tick();
    wb_ld_reg = 0;
    checks++; if (busy_mask !== '0 || sb_err !== 1'b0) begin
      errors++; $display("FAIL same_count1 got busy=%b err=%b exp 0/0", busy_mask, sb_err); end
  endtask

  task automatic test_mem_stall();
    logic [PW-1:0] p, q;
    do_reset();
    p = rnd_pay(); q = ~p;
    de_v = 1; de_ld_reg = 1; de_dr_id = 4; de_payload = p;
    tick();
    mem_stall = 1; de_dr_id = 5; de_payload = q;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (ld_agex !== 1'b0) begin errors++; $display("FAIL ms_ld_agex%0d got %b exp 0", k, ld_agex); end
      tick();
      checks++; if (agex_v !== 1'b1 || agex_payload !== p || agex_drid !== 3'd4 || busy_mask !== 8'b0001_0000) begin
        errors++; $display("FAIL ms_hold%0d got v=%b p=%h dr=%0d busy=%b exp p=%h", k, agex_v, agex_payload, agex_drid, busy_mask, p); end
    end
    mem_stall = 0;
    tick();
    checks++; if (agex_payload !== q || agex_drid !== 3'd5 || busy_mask !== 8'b0011_0000) begin
      errors++; $display("FAIL ms_release got p=%h dr=%0d busy=%b exp p=%h dr=5 busy=00110000", agex_payload, agex_drid, busy_mask, q); end
    idle();
  endtask

  task automatic test_underflow();
    do_reset();
    wb_ld_reg = 1; wb_drid = 5;
    tick();
    checks++; if (sb_err !== 1'b1 || busy_mask !== '0) begin
      errors++; $display("FAIL uf_set got err=%b busy=%b exp 1/0", sb_err, busy_mask); end
    idle(); de_v = 1; de_ld_cc = 1;
    tick();
    checks++; if (sb_err !== 1'b1 || cc_pending !== 1'b1) begin
      errors++; $display("FAIL uf_sticky got err=%b cc=%b exp 1/1", sb_err, cc_pending); end
    idle(); reset = 1;
    tick();
    checks++; if (sb_err !== 1'b0 || busy_mask !== '0 || cc_pending !== 1'b0) begin
      errors++; $display("FAIL uf_clear got err=%b busy=%b cc=%b exp 0", sb_err, busy_mask, cc_pending); end
    reset = 0;
  endtask

  task automatic test_flush();
    logic [PW-1:0] p;
    do_reset();
    de_v = 1; de_ld_reg = 1; de_dr_id = 4; flush = 1;
    tick();
    checks++; if (agex_v !== 1'b0 || busy_mask !== '0) begin
      errors++; $display("FAIL flush_squash got v=%b busy=%b exp 0/0", agex_v, busy_mask); end
    p = rnd_pay(); flush = 0; de_dr_id = 6; de_payload = p;
    tick();
    flush = 1; mem_stall = 1; de_payload = ~p;
    tick();
    checks++; if (agex_v !== 1'b1 || agex_payload !== p || busy_mask !== 8'b0100_0000) begin
      errors++; $display("FAIL flush_agex got v=%b p=%h busy=%b exp 1/%h/01000000", agex_v, agex_payload, busy_mask, p); end
    idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(63) == 0);
      de_v = $urandom_range(3) != 0;
      de_sr1_id = RW'($urandom); de_sr2_id = RW'($urandom); de_dr_id = RW'($urandom);
      de_sr1_needed = $urandom_range(2) == 0; de_sr2_needed = $urandom_range(3) == 0;
      de_ld_reg = $urandom_range(1); de_ld_cc = $urandom_range(3) == 0; de_br_op = $urandom_range(5) == 0;
      de_payload = rnd_pay();
      mem_stall = $urandom_range(3) == 0; flush = $urandom_range(7) == 0;
      wb_drid = RW'($urandom);
      wb_ld_reg = $urandom_range(2) == 0 && (m_cnt[wb_drid] != 0 || $urandom_range(31) == 0);
      wb_ld_cc = $urandom_range(2) == 0 && (m_cc != 0 || $urandom_range(31) == 0);
      #1;
      checks++; if (dep_stall !== m_stall()) begin errors++; $display("FAIL rnd_stall@%0d got %b exp %b", n, dep_stall, m_stall()); end
      checks++; if (ld_agex !== ~mem_stall) begin errors++; $display("FAIL rnd_ld_agex@%0d got %b exp %b", n, ld_agex, ~mem_stall); end
      tick();
      checks++; if (agex_v !== m_agv || agex_payload !== m_pay || agex_drid !== m_drid || agex_ld_reg !== m_alr || agex_ld_cc !== m_alc) begin
        errors++; $display("FAIL rnd_agex@%0d got v=%b p=%h dr=%0d lr=%b lc=%b exp v=%b p=%h dr=%0d lr=%b lc=%b",
          n, agex_v, agex_payload, agex_drid, agex_ld_reg, agex_ld_cc, m_agv, m_pay, m_drid, m_alr, m_alc); end
      checks++; if (busy_mask !== m_busy() || cc_pending !== (m_cc != 0) || sb_err !== m_err) begin
        errors++; $display("FAIL rnd_sb@%0d got busy=%b cc=%b err=%b exp busy=%b cc=%b err=%b",
          n, busy_mask, cc_pending, sb_err, m_busy(), m_cc != 0, m_err); end
    end
    idle();
  endtask

  initial begin
    idle();
    for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
    m_cc = 0; m_err = 0; m_agv = 0; m_pay = '0; m_drid = '0; m_alr = 0; m_alc = 0;
    @(negedge clk);
    test_reset();
    test_raw();
    test_back_to_back();
    test_same_cycle();
    test_mem_stall();
    test_underflow();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
